ntt_addr_sequencer: RTL and testbench
=====================================

NTT_ADDR_SEQUENCER -- requirements
Module: ntt_addr_sequencer

Interface
REQ-001 Parameter LOGN, default 10, log2 of transform length; N = 2^LOGN; legal range 2..12.
REQ-002 Parameter STAGE_GAP, default 4, idle cycles inserted between stages for butterfly pipeline drain; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a full transform; sampled only in IDLE.
REQ-006 inverse  input  1  mode, sampled with start: 0 = forward (stage 0 up to LOGN-1), 1 = inverse (stage LOGN-1 down to 0).
REQ-007 out_valid  output  1  current address pair is valid.
REQ-008 out_ready  input  1  consumer accepts the pair; transfer occurs when out_valid && out_ready.
REQ-009 addr0  output  LOGN  lower butterfly address.
REQ-010 addr1  output  LOGN  upper butterfly address.
REQ-011 tw_idx  output  LOGN-1  twiddle index.
REQ-012 stage  output  $clog2(LOGN)  current stage number p.
REQ-013 last_in_stage  output  1  current pair is the final pair of its stage.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse on completion.

Function
REQ-016 FSM states IDLE, RUN, GAP, FIN; IDLE->RUN on start; RUN->GAP after the handshake of the last pair of a non-final stage when STAGE_GAP>0, else RUN->RUN at the next stage; GAP->RUN after exactly STAGE_GAP cycles; RUN->FIN after the handshake of the last pair of the final stage; FIN->IDLE unconditionally.
REQ-017 Per stage, butterfly counter j runs 0..N/2-1; i = j mod 2^p, k = j >> p.
REQ-018 addr0 = (k << (p+1)) + i, i.e. j with a 0 inserted at bit p; addr1 = addr0 with bit p set.
REQ-019 tw_idx = i << (LOGN-1-p), truncated to LOGN-1 bits.
REQ-020 All outputs are registered; out_valid rises in the cycle after start is sampled in IDLE, carrying j=0 of the first stage.
REQ-021 While out_valid && !out_ready, all data outputs hold stable.
REQ-022 j advances only on handshake and wraps from N/2-1 to 0 at a stage change.
REQ-023 out_valid is low in IDLE, GAP and FIN; no pair is ever skipped or duplicated.
REQ-024 done pulses in the FIN cycle, one cycle after the final handshake; busy deasserts in the following cycle.
REQ-025 start is ignored while busy; inverse is latched only at accepted start.
REQ-026 Total handshakes per transform = LOGN*N/2; with out_ready held high, start-to-done = LOGN*N/2 + (LOGN-1)*STAGE_GAP + 1 cycles.

Reset
REQ-027 rst forces IDLE, j=0, gap counter 0, and all outputs 0, in any state including mid-transform, taking priority over start and handshake.
REQ-028 After reset the block accepts a new start in the first cycle rst is low.

Structure
REQ-029 Shared package ntt_pkg holds the default LOGN, the FSM state enum, and derived width constants.
REQ-030 One combinational sub-module, ntt_bit_insert, inserts a given bit value at position p of a LOGN-1-bit value; two instances produce addr0 and addr1.

Verification
REQ-031 LOGN=3, STAGE_GAP=0, forward, ready high -> pairs (0,1)(2,3)(4,5)(6,7) | (0,2)(1,3)(4,6)(5,7) | (0,4)(1,5)(2,6)(3,7); done 13 cycles after start.
REQ-032 LOGN=3, forward, stage 2 -> tw_idx 0,1,2,3; stage 0 -> tw_idx 0,0,0,0; last_in_stage high on the 4th pair of each stage.
REQ-033 LOGN=3, inverse=1 -> stage order 2,1,0, with stage 2 pairs (0,4)(1,5)(2,6)(3,7) first.
REQ-034 LOGN=3, STAGE_GAP=2 -> exactly 2 cycles with out_valid low between stages; start-to-done = 17 cycles.
REQ-035 Random out_ready stalls -> outputs stable while stalled; 12 unique in-order transfers; start pulsed mid-run is ignored.
REQ-036 rst asserted during stage 1 -> next cycle all outputs 0 and busy low; a new start then yields pair (0,1) at stage 0.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT butterfly address sequencer: defaults,
// FSM state encoding and derived width helpers.
package ntt_pkg;

  localparam int DEFAULT_LOGN      = 10;
  localparam int DEFAULT_STAGE_GAP = 4;
  localparam int GAP_W             = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  function automatic int stage_width(input int logn);
    return (logn < 2) ? 1 : $clog2(logn);
  endfunction

  localparam int DEFAULT_ADDR_W  = DEFAULT_LOGN;
  localparam int DEFAULT_TW_W    = DEFAULT_LOGN - 1;
  localparam int DEFAULT_STAGE_W = $clog2(DEFAULT_LOGN);

endpackage

// File: rtl/ntt_addr_sequencer_if.sv
// Address-pair stream from the sequencer to the butterfly datapath.
interface ntt_addr_sequencer_if
  import ntt_pkg::*;
#(
  parameter int LOGN = DEFAULT_LOGN
);
  localparam int SW = stage_width(LOGN);

  // A pair transfers on a rising edge where out_valid && out_ready; once
  // out_valid is high it and every payload field stay stable until transfer.
  logic              out_valid;
  logic              out_ready;
  logic [LOGN-1:0]   addr0;
  logic [LOGN-1:0]   addr1;
  logic [LOGN-2:0]   tw_idx;
  logic [SW-1:0]     stage;
  logic              last_in_stage;

  modport master (
    output out_valid, addr0, addr1, tw_idx, stage, last_in_stage,
    input  out_ready
  );

  modport slave (
    input  out_valid, addr0, addr1, tw_idx, stage, last_in_stage,
    output out_ready
  );

endinterface

// File: rtl/ntt_bit_insert.sv
// Widens a LOGN-1 bit value to LOGN bits by inserting bit_val at position pos.
module ntt_bit_insert
  import ntt_pkg::*;
#(
  parameter int LOGN = DEFAULT_LOGN,
  parameter int SW   = stage_width(LOGN)
) (
  input  logic [LOGN-2:0] val,
  input  logic [SW-1:0]   pos,
  input  logic            bit_val,
  output logic [LOGN-1:0] result
);

  logic [LOGN-1:0] wide;
  logic [LOGN-1:0] low_mask;

  always_comb begin
    wide     = {1'b0, val};
    low_mask = (LOGN'(1) << pos) - LOGN'(1);
    result   = ((wide & ~low_mask) << 1) | (wide & low_mask) | (LOGN'(bit_val) << pos);
  end

endmodule

// File: rtl/ntt_addr_sequencer.sv
// Generates radix-2 NTT butterfly address pairs and twiddle indices stage by
// stage, with optional idle gaps between stages for pipeline drain.
module ntt_addr_sequencer
  import ntt_pkg::*;
#(
  parameter int LOGN      = DEFAULT_LOGN,
  parameter int STAGE_GAP = DEFAULT_STAGE_GAP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  inverse,
  ntt_addr_sequencer_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output state_t                dbg_state
);

  localparam int SW = stage_width(LOGN);
  localparam int W  = LOGN - 1;

  localparam logic [W-1:0]     J_LAST   = '1;
  localparam logic [SW-1:0]    P_LAST   = SW'(LOGN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (STAGE_GAP > 0) ? GAP_W'(STAGE_GAP - 1) : '0;

  state_t            state, state_n;
  logic [W-1:0]      j, j_n;
  logic [SW-1:0]     p, p_n;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;
  logic              inv, inv_n;

  logic              valid_q, last_q, busy_q, done_q;
  logic [LOGN-1:0]   addr0_q, addr1_q;
  logic [W-1:0]      tw_q;
  logic [SW-1:0]     stage_q;

  logic              handshake;
  logic              final_stage;
  logic [SW-1:0]     p_next_stage;
  logic [LOGN-1:0]   addr0_n, addr1_n;
  logic [W-1:0]      i_mask_n, i_n, tw_n;

  assign handshake    = valid_q & bus.out_ready;
  assign final_stage  = inv ? (p == '0) : (p == P_LAST);
  assign p_next_stage = inv ? (p - SW'(1)) : (p + SW'(1));

  always_comb begin
    state_n   = state;
    j_n       = j;
    p_n       = p;
    gap_cnt_n = gap_cnt;
    inv_n     = inv;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n   = RUN;
          j_n       = '0;
          gap_cnt_n = '0;
          inv_n     = inverse;
          p_n       = inverse ? P_LAST : '0;
        end
      end
      RUN: begin
        if (handshake) begin
          if (j == J_LAST) begin
            j_n = '0;
            if (final_stage) begin
              state_n = FIN;
            end else begin
              p_n       = p_next_stage;
              gap_cnt_n = '0;
              if (STAGE_GAP > 0) state_n = GAP;
            end
          end else begin
            j_n = j + W'(1);
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n   = RUN;
          gap_cnt_n = '0;
        end else begin
          gap_cnt_n = gap_cnt + GAP_W'(1);
        end
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are computed from next-state values so they can be registered
  // without adding a cycle of latency.
  ntt_bit_insert #(.LOGN(LOGN), .SW(SW)) u_ins0 (
    .val(j_n), .pos(p_n), .bit_val(1'b0), .result(addr0_n)
  );

  ntt_bit_insert #(.LOGN(LOGN), .SW(SW)) u_ins1 (
    .val(j_n), .pos(p_n), .bit_val(1'b1), .result(addr1_n)
  );

  always_comb begin
    i_mask_n = (W'(1) << p_n) - W'(1);
    i_n      = j_n & i_mask_n;
    tw_n     = i_n << (P_LAST - p_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      j       <= '0;
      p       <= '0;
      gap_cnt <= '0;
      inv     <= 1'b0;
      valid_q <= 1'b0;
      addr0_q <= '0;
      addr1_q <= '0;
      tw_q    <= '0;
      stage_q <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      j       <= j_n;
      p       <= p_n;
      gap_cnt <= gap_cnt_n;
      inv     <= inv_n;
      valid_q <= (state_n == RUN);
      addr0_q <= addr0_n;
      addr1_q <= addr1_n;
      tw_q    <= tw_n;
      stage_q <= p_n;
      last_q  <= (state_n == RUN) && (j_n == J_LAST);
      busy_q  <= (state_n != IDLE);
      done_q  <= (state_n == FIN);
    end
  end

  assign bus.out_valid     = valid_q;
  assign bus.addr0         = addr0_q;
  assign bus.addr1         = addr1_q;
  assign bus.tw_idx        = tw_q;
  assign bus.stage         = stage_q;
  assign bus.last_in_stage = last_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign dbg_state         = state;

endmodule

// File: tb/tb_ntt_addr_sequencer.sv
// Directed bench for ntt_addr_sequencer at LOGN=3, with STAGE_GAP 0 and 2.
module tb_ntt_addr_sequencer;
  import ntt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic inverse = 1'b0;
  logic rdy = 1'b1;
  logic sel = 1'b0;

  logic   busy0, done0, busy2, done2;
  state_t st0, st2;

  ntt_addr_sequencer_if #(.LOGN(3)) bus0 ();
  ntt_addr_sequencer_if #(.LOGN(3)) bus2 ();

  assign bus0.out_ready = rdy;
  assign bus2.out_ready = rdy;

  ntt_addr_sequencer #(.LOGN(3), .STAGE_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .inverse(inverse),
    .bus(bus0), .busy(busy0), .done(done0), .dbg_state(st0)
  );

  ntt_addr_sequencer #(.LOGN(3), .STAGE_GAP(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .inverse(inverse),
    .bus(bus2), .busy(busy2), .done(done2), .dbg_state(st2)
  );

  always #5 clk = ~clk;

  // Observed view of whichever DUT the current step targets
  logic       obs_valid, obs_last, obs_busy, obs_done;
  logic [2:0] obs_a0, obs_a1;
  logic [1:0] obs_tw, obs_stage;
  state_t     obs_state;
  always_comb begin
    obs_valid = sel ? bus2.out_valid     : bus0.out_valid;
    obs_last  = sel ? bus2.last_in_stage : bus0.last_in_stage;
    obs_a0    = sel ? bus2.addr0         : bus0.addr0;
    obs_a1    = sel ? bus2.addr1         : bus0.addr1;
    obs_tw    = sel ? bus2.tw_idx        : bus0.tw_idx;
    obs_stage = sel ? bus2.stage         : bus0.stage;
    obs_busy  = sel ? busy2              : busy0;
    obs_done  = sel ? done2              : done0;
    obs_state = sel ? st2                : st0;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [10:0] exp_q[$];

  // Forward-order reference pairs for N=8, stages 0,1,2
  int fa0[12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int fa1[12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int ftw[12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] cur_pair();
    return {obs_a0, obs_a1, obs_tw, obs_stage, obs_last};
  endfunction

  task automatic load_expected(input bit inv);
    exp_q.delete();
    for (int n = 0; n < 12; n++) begin
      int idx;
      int st;
      idx = inv ? ((2 - n / 4) * 4 + n % 4) : n;
      st  = idx / 4;
      exp_q.push_back({3'(fa0[idx]), 3'(fa1[idx]), 2'(ftw[idx]), 2'(st), (n % 4 == 3)});
    end
  endtask

  task automatic wait_all_idle();
    int guard = 0;
    rdy = 1'b1;
    while ((busy0 || busy2) && guard < 200) begin
      step();
      guard++;
    end
    check("all_idle", {30'd0, busy0, busy2}, 32'd0);
  endtask

  // Runs one transform on the selected DUT, scoring every transfer in order.
  task automatic run_transform(input bit inv, input bit rnd, input bit poke,
                               input int exp_cycles, input int exp_gap);
    int cyc = 0;
    int ntrans = 0;
    int low_run = 0;
    int gaps[$];
    bit held = 1'b0;
    logic [10:0] held_v = '0;
    logic [10:0] cur;
    load_expected(inv);
    rdy = 1'b1;
    start = 1'b1;
    inverse = inv;
    step();
    start = 1'b0;
    inverse = 1'b0;
    cyc = 1;
    while (!obs_done && cyc < 400) begin
      cur = cur_pair();
      if (held) begin
        check("hold_valid", {31'd0, obs_valid}, 32'd1);
        check("hold_data", {21'd0, cur}, {21'd0, held_v});
        held = 1'b0;
      end
      if (obs_valid) begin
        if (low_run > 0 && ntrans > 0) gaps.push_back(low_run);
        low_run = 0;
      end else if (ntrans > 0) begin
        low_run++;
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && cyc == 5) begin
        start = 1'b1;
        inverse = ~inv;
      end else begin
        start = 1'b0;
        inverse = 1'b0;
      end
      if (obs_valid && rdy) begin
        if (exp_q.size() == 0) begin
          check("pair_count", ntrans, 12);
        end else begin
          check("pair", {21'd0, cur}, {21'd0, exp_q.pop_front()});
        end
        ntrans++;
      end else if (obs_valid) begin
        held = 1'b1;
        held_v = cur;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    rdy = 1'b1;
    check("done_seen", {31'd0, obs_done}, 32'd1);
    check("fin_state", {30'd0, obs_state}, {30'd0, FIN});
    check("fin_busy", {31'd0, obs_busy}, 32'd1);
    check("transfers", ntrans, 12);
    check("exp_q_empty", exp_q.size(), 0);
    if (exp_cycles >= 0) check("start_to_done", cyc, exp_cycles);
    if (exp_gap >= 0) begin
      check("gap_count", gaps.size(), (exp_gap > 0) ? 2 : 0);
      foreach (gaps[g]) check("gap_len", gaps[g], exp_gap);
    end
    step();
    check("done_pulse", {31'd0, obs_done}, 32'd0);
    check("busy_drop", {31'd0, obs_busy}, 32'd0);
    wait_all_idle();
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    step();
    step();
    sel = 1'b0;
    check("rst_valid", {31'd0, obs_valid}, 32'd0);
    check("rst_busy", {31'd0, obs_busy}, 32'd0);
    check("rst_done", {31'd0, obs_done}, 32'd0);
    check("rst_pair", {21'd0, cur_pair()}, 32'd0);
    check("rst_state", {30'd0, obs_state}, {30'd0, IDLE});
    rst = 1'b0;
    step();

    // Forward, ready high, no gap
    sel = 1'b0;
    run_transform(1'b0, 1'b0, 1'b0, 13, 0);

    // Inverse: stage order 2,1,0
    sel = 1'b0;
    run_transform(1'b1, 1'b0, 1'b0, 13, 0);

    // Two idle cycles between stages
    sel = 1'b1;
    run_transform(1'b0, 1'b0, 1'b0, 17, 2);

    // Random back-pressure with a stray start mid-run
    sel = 1'b0;
    run_transform(1'b0, 1'b1, 1'b1, -1, -1);
    sel = 1'b0;
    run_transform(1'b1, 1'b1, 1'b0, -1, -1);

    // Reset in the middle of stage 1
    sel = 1'b0;
    rdy = 1'b1;
    start = 1'b1;
    inverse = 1'b0;
    step();
    start = 1'b0;
    guard = 0;
    while (!(obs_valid && obs_stage == 2'd1 && obs_a0 == 3'd1) && guard < 50) begin
      step();
      guard++;
    end
    check("reach_stage1", {30'd0, obs_stage}, 32'd1);
    rst = 1'b1;
    step();
    check("mid_rst_valid", {31'd0, obs_valid}, 32'd0);
    check("mid_rst_pair", {21'd0, cur_pair()}, 32'd0);
    check("mid_rst_busy", {31'd0, obs_busy}, 32'd0);
    check("mid_rst_done", {31'd0, obs_done}, 32'd0);
    check("mid_rst_state", {30'd0, obs_state}, {30'd0, IDLE});
    rst = 1'b0;
    start = 1'b1;
    inverse = 1'b0;
    step();
    start = 1'b0;
    check("restart_valid", {31'd0, obs_valid}, 32'd1);
    check("restart_pair", {21'd0, cur_pair()}, {21'd0, 3'd0, 3'd1, 2'd0, 2'd0, 1'b0});
    wait_all_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
